// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM bundle interface: upstream valid/ready, downstream valid/ready,
// flush and the stall monitor. The pipe register uses the slave modport.
interface ex_mem_pipe_reg_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CTRL_W      = 5,
  parameter int unsigned STALL_CNT_W = 16
);
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [CTRL_W-1:0]      control;
  logic                   zero;
  logic [DATA_W-1:0]      alu_result;
  logic [DATA_W-1:0]      read_data_2;
  logic [REG_ADDR_W-1:0]  dst_reg;
  logic [DATA_W-1:0]      branch_target;
  logic                   out_valid;
  logic                   out_ready;
  logic [CTRL_W-1:0]      control_out;
  logic                   zero_out;
  logic [DATA_W-1:0]      alu_result_out;
  logic [DATA_W-1:0]      read_data_2_out;
  logic [REG_ADDR_W-1:0]  dst_reg_out;
  logic [DATA_W-1:0]      branch_target_out;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport slave (
    input  flush, in_valid, control, zero, alu_result, read_data_2, dst_reg,
           branch_target, out_ready,
    output in_ready, out_valid, control_out, zero_out, alu_result_out,
           read_data_2_out, dst_reg_out, branch_target_out, stall_cycles
  );

  modport master (
    output flush, in_valid, control, zero, alu_result, read_data_2, dst_reg,
           branch_target, out_ready,
    input  in_ready, out_valid, control_out, zero_out, alu_result_out,
           read_data_2_out, dst_reg_out, branch_target_out, stall_cycles
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: 2-entry elastic buffer (main + skid) with
// flush, bubble-gated control output and a saturating stall counter.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CTRL_W      = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  ex_mem_pipe_reg_if.slave   bus
);

  typedef struct packed {
    logic [CTRL_W-1:0]     control;
    logic                  zero;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     read_data_2;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [DATA_W-1:0]     branch_target;
  } bundle_t;

  // EMPTY: nothing held; MAIN: main valid; FULL: main and skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t                   state_q, state_d;
  bundle_t                main_q, main_d;
  bundle_t                skid_q, skid_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  bundle_t in_bundle;
  logic    main_v, skid_v;
  logic    accept, consume;

  always_comb begin
    in_bundle = '{control:       bus.control,
                  zero:          bus.zero,
                  alu_result:    bus.alu_result,
                  read_data_2:   bus.read_data_2,
                  dst_reg:       bus.dst_reg,
                  branch_target: bus.branch_target};
    main_v  = (state_q != EMPTY);
    skid_v  = (state_q == FULL);
    accept  = bus.in_valid & ~skid_v;
    consume = main_v & bus.out_ready;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if (main_v && !bus.out_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end

    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_bundle;
            state_d = MAIN;
          end
        end
        MAIN: begin
          if (consume && accept) begin
            main_d = in_bundle;
          end else if (consume) begin
            state_d = EMPTY;
          end else if (accept) begin
            skid_d  = in_bundle;
            state_d = FULL;
          end
        end
        FULL: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = MAIN;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // in_ready comes from state alone, so no combinational path from out_ready
  assign bus.in_ready          = ~skid_v;
  assign bus.out_valid         = main_v;
  assign bus.control_out       = main_v ? main_q.control : '0;
  assign bus.zero_out          = main_q.zero;
  assign bus.alu_result_out    = main_q.alu_result;
  assign bus.read_data_2_out   = main_q.read_data_2;
  assign bus.dst_reg_out       = main_q.dst_reg;
  assign bus.branch_target_out = main_q.branch_target;
  assign bus.stall_cycles      = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: default-width instance plus a
// 3-bit stall counter instance for the saturation case.
module tb_ex_mem_pipe_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(5), .STALL_CNT_W(16)) b ();
  ex_mem_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(5), .STALL_CNT_W(3))  s ();

  ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(5), .STALL_CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(5), .STALL_CNT_W(3)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (s.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] ctl, input logic [31:0] alu);
    b.in_valid   = v;
    b.control    = ctl;
    b.alu_result = alu;
  endtask

  initial begin
    b.flush = 1'b0; b.in_valid = 1'b0; b.control = '0; b.zero = 1'b0;
    b.alu_result = '0; b.read_data_2 = '0; b.dst_reg = '0; b.branch_target = '0;
    b.out_ready = 1'b1;
    s.flush = 1'b0; s.in_valid = 1'b0; s.control = '0; s.zero = 1'b0;
    s.alu_result = '0; s.read_data_2 = '0; s.dst_reg = '0; s.branch_target = '0;
    s.out_ready = 1'b1;

    // reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(b.out_valid), 64'h0);
    chk("rst_in_ready",  64'(b.in_ready),  64'h1);
    chk("rst_control",   64'(b.control_out), 64'h0);
    chk("rst_alu",       64'(b.alu_result_out), 64'h0);
    chk("rst_bt",        64'(b.branch_target_out), 64'h0);
    chk("rst_stall",     64'(b.stall_cycles), 64'h0);
    chk("rst_sat_stall", 64'(s.stall_cycles), 64'h0);

    // streaming
    b.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(i + 1), 32'((i + 1) * 16));
      tick();
      chk("stream_valid", 64'(b.out_valid), 64'h1);
      chk("stream_alu",   64'(b.alu_result_out), 64'((i + 1) * 16));
      chk("stream_ctl",   64'(b.control_out), 64'(i + 1));
      chk("stream_ready", 64'(b.in_ready), 64'h1);
    end
    // bubble gating
    drive(1'b0, 5'b11111, 32'hdead);
    tick();
    chk("bubble_valid", 64'(b.out_valid), 64'h0);
    chk("bubble_ctl",   64'(b.control_out), 64'h0);
    chk("stream_stall", 64'(b.stall_cycles), 64'h0);

    // back-pressure
    b.out_ready = 1'b0;
    drive(1'b1, 5'h03, 32'h11);
    tick();
    chk("bp_A_valid", 64'(b.out_valid), 64'h1);
    chk("bp_A_alu",   64'(b.alu_result_out), 64'h11);
    chk("bp_A_ready", 64'(b.in_ready), 64'h1);
    chk("bp_stall0",  64'(b.stall_cycles), 64'h0);
    drive(1'b1, 5'h05, 32'h22);
    tick();
    chk("bp_hold_alu", 64'(b.alu_result_out), 64'h11);
    chk("bp_ready0",   64'(b.in_ready), 64'h0);
    chk("bp_stall1",   64'(b.stall_cycles), 64'h1);
    drive(1'b0, 5'h00, 32'h0);
    tick();
    chk("bp_hold2_alu", 64'(b.alu_result_out), 64'h11);
    chk("bp_hold2_ctl", 64'(b.control_out), 64'h03);
    chk("bp_stall2",    64'(b.stall_cycles), 64'h2);
    b.out_ready = 1'b1;
    tick();
    chk("bp_B_alu",   64'(b.alu_result_out), 64'h22);
    chk("bp_B_ctl",   64'(b.control_out), 64'h05);
    chk("bp_B_ready", 64'(b.in_ready), 64'h1);
    chk("bp_stall_k", 64'(b.stall_cycles), 64'h2);
    tick();
    chk("bp_drained", 64'(b.out_valid), 64'h0);

    // flush with both entries full and a bundle offered
    b.out_ready = 1'b0;
    drive(1'b1, 5'h01, 32'h44);
    tick();
    drive(1'b1, 5'h02, 32'h55);
    tick();
    chk("fl_full_ready", 64'(b.in_ready), 64'h0);
    chk("fl_stall3",     64'(b.stall_cycles), 64'h3);
    b.flush = 1'b1;
    drive(1'b1, 5'h1f, 32'h33);
    tick();
    b.flush = 1'b0;
    chk("fl_valid", 64'(b.out_valid), 64'h0);
    chk("fl_ctl",   64'(b.control_out), 64'h0);
    chk("fl_ready", 64'(b.in_ready), 64'h1);
    chk("fl_stall_kept", 64'(b.stall_cycles), 64'h4);
    drive(1'b0, 5'h00, 32'h0);
    b.out_ready = 1'b1;
    tick();
    chk("fl_no_C", 64'(b.out_valid), 64'h0);

    // flush with main only, offered bundle discarded
    drive(1'b1, 5'h04, 32'h66);
    tick();
    chk("fl2_main", 64'(b.alu_result_out), 64'h66);
    b.flush = 1'b1;
    drive(1'b1, 5'h04, 32'h77);
    tick();
    b.flush = 1'b0;
    drive(1'b0, 5'h00, 32'h0);
    chk("fl2_valid", 64'(b.out_valid), 64'h0);
    tick();
    chk("fl2_no_new", 64'(b.out_valid), 64'h0);

    // reset mid-stream with a held entry
    b.out_ready = 1'b0;
    drive(1'b1, 5'h09, 32'h88);
    b.zero = 1'b1; b.read_data_2 = 32'habc; b.dst_reg = 5'd7; b.branch_target = 32'h1234;
    tick();
    chk("ms_dst", 64'(b.dst_reg_out), 64'h7);
    chk("ms_bt",  64'(b.branch_target_out), 64'h1234);
    chk("ms_rd2", 64'(b.read_data_2_out), 64'habc);
    chk("ms_zero", 64'(b.zero_out), 64'h1);
    drive(1'b0, 5'h00, 32'h0);
    b.zero = 1'b0; b.read_data_2 = '0; b.dst_reg = '0; b.branch_target = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 64'(b.out_valid), 64'h0);
    chk("mr_ctl",   64'(b.control_out), 64'h0);
    chk("mr_alu",   64'(b.alu_result_out), 64'h0);
    chk("mr_dst",   64'(b.dst_reg_out), 64'h0);
    chk("mr_zero",  64'(b.zero_out), 64'h0);
    chk("mr_stall", 64'(b.stall_cycles), 64'h0);
    chk("mr_ready", 64'(b.in_ready), 64'h1);
    b.out_ready = 1'b1;
    drive(1'b1, 5'h01, 32'h99);
    tick();
    chk("mr_resume", 64'(b.alu_result_out), 64'h99);
    chk("mr_resume_v", 64'(b.out_valid), 64'h1);
    drive(1'b0, 5'h00, 32'h0);

    // saturation on the 3-bit counter
    s.out_ready = 1'b0;
    s.in_valid = 1'b1; s.alu_result = 32'h1; s.control = 5'h01;
    tick();
    s.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("sat_mid", 64'(s.stall_cycles), 64'h3);
    for (int i = 0; i < 7; i++) tick();
    chk("sat_top",   64'(s.stall_cycles), 64'h7);
    tick();
    chk("sat_stay",  64'(s.stall_cycles), 64'h7);
    chk("sat_valid", 64'(s.out_valid), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised EX/MEM pipeline register with a valid/ready handshake.
- Carries the execute-stage bundle (control, zero, ALU result, store data, destination register, branch target) into the memory stage.
- Adds a 2-entry elastic buffer (main plus skid) so back-pressure from the memory stage never loses or duplicates an instruction.
- Adds synchronous flush for branch squash and a saturating stall counter for performance monitoring.

Parameters:
- DATA_W, 32, width of alu_result, read_data_2 and branch_target.
- REG_ADDR_W, 5, width of dst_reg.
- CTRL_W, 5, width of the control bundle (RegWrite, MemtoReg, MemRead, MemWrite, Branch).
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all held entries (branch taken / exception).
- in_valid  in  1  EX stage presents a valid bundle.
- in_ready  out  1  block can accept a bundle this cycle.
- control  in  CTRL_W  control bundle.
- zero  in  1  ALU zero flag.
- alu_result  in  DATA_W  ALU result.
- read_data_2  in  DATA_W  store data.
- dst_reg  in  REG_ADDR_W  destination register.
- branch_target  in  DATA_W  computed branch target.
- out_valid  out  1  MEM stage bundle valid.
- out_ready  in  1  MEM stage consumes the bundle this cycle.
- control_out  out  CTRL_W  forced to 0 whenever out_valid=0.
- zero_out  out  1  registered zero.
- alu_result_out  out  DATA_W  registered alu_result.
- read_data_2_out  out  DATA_W  registered read_data_2.
- dst_reg_out  out  REG_ADDR_W  registered dst_reg.
- branch_target_out  out  DATA_W  registered branch_target.
- stall_cycles  out  STALL_CNT_W  saturating count of back-pressure cycles.

Behaviour:
- Storage: main register (drives outputs) plus skid register, each with a valid bit (main_v, skid_v).
- Timing: rising-edge only; no negedge clocking, no delay statements.
- Handshake signals:
  - in_ready = ~skid_v. It is derived from state only, with no combinational path from out_ready or in_valid.
  - Accept = in_valid & in_ready. Consume = out_valid & out_ready. out_valid = main_v.
- Latency and throughput: 1 cycle from accept to out_valid. Sustains 1 bundle/cycle when out_ready stays high.
- Transitions, non-flush cycle:
  - Empty (main_v=0): accept loads main, main_v<=1.
  - Main only, consume & accept: main<=input.
  - Main only, consume & no accept: main_v<=0.
  - Main only, no consume & accept: skid<=input, skid_v<=1. in_ready drops next cycle.
  - Main only, no consume & no accept: hold.
  - Both full (in_ready=0): on consume main<=skid, skid_v<=0. Otherwise hold.
- Ordering: strict FIFO. A bundle is never dropped, duplicated or reordered.
- Held payload: stable while out_valid=1 & out_ready=0.
- Flush:
  - flush=1 clears main_v and skid_v at the edge.
  - Any bundle offered in the same cycle is discarded.
  - in_ready=1 the next cycle.
- Priority: rst > flush > normal operation.
- control_out gating: control_out = main_v ? stored control : 0, so no downstream write or memory enable fires from a bubble.
- Stall counter: increments when out_valid & ~out_ready and saturates at all-ones (no wrap). It is cleared by rst only; flush does not clear it.
- Reset values:
  - main_v=0, skid_v=0, out_valid=0, control_out=0.
  - zero_out=0, alu_result_out=0, read_data_2_out=0, dst_reg_out=0, branch_target_out=0, stall_cycles=0.
  - in_ready=1 from the first cycle after rst deasserts.
- Reset mid-operation: all held bundles are discarded; no partial output appears.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 4 cycles with alu_result 0x10,0x20,0x30,0x40 -> outputs same values on 4 consecutive cycles one cycle later; in_ready stays 1; stall_cycles=0.
- Back-pressure:
  - Stimulus: send A=0x11 then B=0x22 with out_ready=0.
  - Required: out shows A held; in_ready=0 after B; stall_cycles increments each cycle.
  - Then raise out_ready: A, then B, then out_valid=0.
- Flush: with both entries full, assert flush together with in_valid (C=0x33) -> next cycle out_valid=0, control_out=0, in_ready=1; C never appears.
- Reset mid-stream: rst=1 while an entry is held -> next cycle every output is 0, stall_cycles=0; normal streaming resumes after deassert.
- Saturation: STALL_CNT_W=3, hold out_valid=1 & out_ready=0 for 10 cycles -> stall_cycles reaches 7 and stays 7.
- Bubble gating: in_valid=0 for a cycle while control=5'b11111 -> control_out=0 and out_valid=0.
